// File: rtl/radarscp_pkg.sv
// Shared types for the Radar Scope background mixer: pixel colour, pipeline record
// and hit-flash states.
package radarscp_pkg;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb8_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } flash_state_t;

  // Everything the colour mux needs for one pixel, captured in S1.
  typedef struct packed {
    logic  hblkn;
    logic  vblkn;
    rgb8_t fg;
    logic  fg_opaque;
    logic  starn;
    logic  radarn;
    logic  noise;
    logic  display;
  } pix_t;

  // Stars are grey; blue only has two bits so it takes the top of the level.
  function automatic rgb8_t star_grey(input logic [2:0] lvl);
    rgb8_t c;
    c.r = lvl;
    c.g = lvl;
    c.b = lvl[2:1];
    return c;
  endfunction

endpackage

// File: rtl/radarscp_flash_fsm.sv
// Hit-flash sequencer: a rising I_SOU2 seen between frame starts launches an
// alternating ON/OFF run of FLASH_FRMS frames.
module radarscp_flash_fsm
  import radarscp_pkg::*;
#(
  parameter int FLASH_FRMS = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic fs_i,
  input  logic sou2_i,
  output logic flash_on_o
);

  localparam logic [3:0] FRM_LOAD = 4'(FLASH_FRMS - 1);

  flash_state_t state_q, state_d;
  logic [3:0]   frm_cnt_q, frm_cnt_d;
  logic         sou2_q, sou2_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      frm_cnt_q <= '0;
      sou2_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      frm_cnt_q <= frm_cnt_d;
      sou2_q    <= sou2_d;
    end
  end

  // Only frame starts move the sequencer; a fresh edge always restarts the full run.
  always_comb begin
    state_d   = state_q;
    frm_cnt_d = frm_cnt_q;
    sou2_d    = sou2_q;
    if (fs_i) begin
      sou2_d = sou2_i;
      if (sou2_i && !sou2_q) begin
        state_d   = ON;
        frm_cnt_d = FRM_LOAD;
      end else begin
        case (state_q)
          ON: begin
            if (frm_cnt_q == 4'd0) begin
              state_d = IDLE;
            end else begin
              state_d   = OFF;
              frm_cnt_d = frm_cnt_q - 4'd1;
            end
          end
          OFF: begin
            if (frm_cnt_q == 4'd0) begin
              state_d = IDLE;
            end else begin
              state_d   = ON;
              frm_cnt_d = frm_cnt_q - 4'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign flash_on_o = (state_q == ON);

endmodule

// File: rtl/radarscp_bg_mixer.sv
// Radar Scope background mixer: two-stage pixel pipeline merging foreground, radar grid
// draw-in, dimmed stars and the hit flash into final RGB plus aligned blanks.
module radarscp_bg_mixer
  import radarscp_pkg::*;
#(
  parameter logic [2:0] STAR_HI     = 3'd7,
  parameter logic [2:0] STAR_LO     = 3'd3,
  parameter logic [7:0] GRID_RGB    = 8'h1F,
  parameter logic [7:0] FLASH_RGB   = 8'hE0,
  parameter logic [7:0] FLASH_BG    = 8'h20,
  parameter int         FLASH_FRMS  = 8,
  parameter int         REVEAL_STEP = 4
) (
  input  logic       CLK_24M,
  input  logic       RESET,
  input  logic       CLK_EN,
  input  logic       I_HBLKn,
  input  logic       I_VBLKn,
  input  logic [7:0] I_FG_RGB,
  input  logic       I_FG_OPAQUE,
  input  logic       I_STARn,
  input  logic       I_RADARn,
  input  logic       I_NOISE,
  input  logic       I_DISPLAY,
  input  logic       I_SOU2,
  output logic [2:0] O_R,
  output logic [2:0] O_G,
  output logic [1:0] O_B,
  output logic       O_HBLKn,
  output logic       O_VBLKn
);

  localparam logic [9:0] REVEAL_MAX = 10'd256;

  pix_t       s1_q, s1_d;
  rgb8_t      rgb_q, rgb_d;
  logic       hblkn_q, vblkn_q;
  logic [7:0] line_cnt_q, line_cnt_d;
  logic [8:0] reveal_q, reveal_d;
  logic [9:0] reveal_sum;
  logic       armed_q, armed_d;
  logic       live_q, live_d;
  logic       fs, line_tick, grid, flash_on;

  assign s1_d = '{hblkn:     I_HBLKn,
                  vblkn:     I_VBLKn,
                  fg:        I_FG_RGB,
                  fg_opaque: I_FG_OPAQUE,
                  starn:     I_STARn,
                  radarn:    I_RADARn,
                  noise:     I_NOISE,
                  display:   I_DISPLAY};

  // A frame start needs a genuine vblank seen since reset, so a reset in mid-frame
  // cannot fake one from the cleared S1 register.
  assign fs        = CLK_EN & I_VBLKn & ~s1_q.vblkn & armed_q;
  assign line_tick = CLK_EN & ~I_HBLKn & s1_q.hblkn & I_VBLKn;
  assign armed_d   = armed_q | ~I_VBLKn;
  assign live_d    = live_q | fs;

  always_comb begin
    line_cnt_d = line_cnt_q;
    if (fs) begin
      line_cnt_d = '0;
    end else if (line_tick && line_cnt_q != 8'hFF) begin
      line_cnt_d = line_cnt_q + 8'd1;
    end
  end

  assign reveal_sum = {1'b0, reveal_q} + 10'(REVEAL_STEP);

  always_comb begin
    reveal_d = reveal_q;
    if (fs) begin
      if (!I_DISPLAY) begin
        reveal_d = '0;
      end else if (reveal_sum > REVEAL_MAX) begin
        reveal_d = REVEAL_MAX[8:0];
      end else begin
        reveal_d = reveal_sum[8:0];
      end
    end
  end

  radarscp_flash_fsm #(
    .FLASH_FRMS (FLASH_FRMS)
  ) u_flash (
    .clk_i      (CLK_24M),
    .rst_i      (RESET),
    .fs_i       (fs),
    .sou2_i     (I_SOU2),
    .flash_on_o (flash_on)
  );

  assign grid = ~s1_q.radarn & s1_q.display & ({1'b0, line_cnt_q} < reveal_q);

  // S2 colour priority: blank, foreground, grid, star, background.
  always_comb begin
    rgb_d = '0;
    if (!live_q || !s1_q.hblkn || !s1_q.vblkn) begin
      rgb_d = '0;
    end else if (s1_q.fg_opaque) begin
      rgb_d = s1_q.fg;
    end else if (grid) begin
      rgb_d = flash_on ? rgb8_t'(FLASH_RGB) : rgb8_t'(GRID_RGB);
    end else if (!s1_q.starn) begin
      rgb_d = star_grey(s1_q.noise ? STAR_LO : STAR_HI);
    end else if (flash_on) begin
      rgb_d = rgb8_t'(FLASH_BG);
    end
  end

  always_ff @(posedge CLK_24M) begin
    if (RESET) begin
      s1_q       <= '0;
      rgb_q      <= '0;
      hblkn_q    <= 1'b0;
      vblkn_q    <= 1'b0;
      line_cnt_q <= '0;
      reveal_q   <= '0;
      armed_q    <= 1'b0;
      live_q     <= 1'b0;
    end else if (CLK_EN) begin
      s1_q       <= s1_d;
      rgb_q      <= rgb_d;
      hblkn_q    <= s1_q.hblkn;
      vblkn_q    <= s1_q.vblkn;
      line_cnt_q <= line_cnt_d;
      reveal_q   <= reveal_d;
      armed_q    <= armed_d;
      live_q     <= live_d;
    end
  end

  assign O_R     = rgb_q.r;
  assign O_G     = rgb_q.g;
  assign O_B     = rgb_q.b;
  assign O_HBLKn = hblkn_q;
  assign O_VBLKn = vblkn_q;

endmodule

// File: tb/tb_radarscp_bg_mixer.sv
// Directed bench for radarscp_bg_mixer: table of single-line colour vectors plus
// hand-built frame sequences for draw-in, flash, clock-enable freeze and reset.
module tb_radarscp_bg_mixer;

  logic       clk = 1'b0;
  logic       rst, en, hblkn, vblkn, fg_op, starn, radarn, noise, display, sou2;
  logic [7:0] fg;
  logic [2:0] o_r, o_g;
  logic [1:0] o_b;
  logic       o_hb, o_vb;
  logic [7:0] rgb;

  int nchk = 0;
  int nerr = 0;

  // one-deep expectation slot: a pixel driven at edge e shows on the outputs after edge e+1
  bit         pv;
  bit         pc;
  logic [7:0] pe;
  string      pn;
  logic       ph, pvb;

  typedef struct {
    logic       fg_op;
    logic [7:0] fg;
    logic       starn;
    logic       radarn;
    logic       noise;
    logic       display;
    logic [7:0] exp;
    string      name;
  } vec_t;

  vec_t        tbl[10];
  logic [8:0]  a_on;
  logic [12:0] b_sou, b_on;

  always #5 clk = ~clk;
  assign rgb = {o_r, o_g, o_b};

  radarscp_bg_mixer dut (
    .CLK_24M     (clk),
    .RESET       (rst),
    .CLK_EN      (en),
    .I_HBLKn     (hblkn),
    .I_VBLKn     (vblkn),
    .I_FG_RGB    (fg),
    .I_FG_OPAQUE (fg_op),
    .I_STARn     (starn),
    .I_RADARn    (radarn),
    .I_NOISE     (noise),
    .I_DISPLAY   (display),
    .I_SOU2      (sou2),
    .O_R         (o_r),
    .O_G         (o_g),
    .O_B         (o_b),
    .O_HBLKn     (o_hb),
    .O_VBLKn     (o_vb)
  );

  task automatic chk(input string n, input logic [7:0] act, input logic [7:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic pix(input logic hb, input logic vb, input bit c, input logic [7:0] e,
                     input string n);
    hblkn = hb;
    vblkn = vb;
    @(posedge clk);
    #1;
    if (pv) begin
      if (pc) chk(pn, rgb, pe);
      chk({pn, "_hblk"}, {7'd0, o_hb}, {7'd0, ph});
      chk({pn, "_vblk"}, {7'd0, o_vb}, {7'd0, pvb});
    end
    pv  = 1'b1;
    pc  = c;
    pe  = e;
    pn  = n;
    ph  = hb;
    pvb = vb;
  endtask

  task automatic vblank(input int k);
    for (int i = 0; i < k; i++) pix(1'b0, 1'b0, 1'b1, 8'h00, "vblank_black");
  endtask

  task automatic line1(input logic [7:0] e, input string n);
    pix(1'b1, 1'b1, 1'b1, e, n);
    pix(1'b0, 1'b1, 1'b1, 8'h00, "hblank_black");
  endtask

  task automatic set_px(input logic fo, input logic [7:0] f, input logic sn, input logic rn,
                        input logic nz);
    fg_op  = fo;
    fg     = f;
    starn  = sn;
    radarn = rn;
    noise  = nz;
  endtask

  task automatic flash_frame(input logic s, input logic on, input string tag);
    sou2 = s;
    vblank(3);
    set_px(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    line1(on ? 8'hE0 : 8'h1F, {tag, "_grid"});
    set_px(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    line1(on ? 8'h20 : 8'h00, {tag, "_bg"});
    set_px(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    line1(8'hFF, {tag, "_star"});
    set_px(1'b1, 8'h55, 1'b1, 1'b1, 1'b0);
    line1(8'h55, {tag, "_fg"});
    fg_op = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; hblkn = 1'b0; vblkn = 1'b0; display = 1'b0; sou2 = 1'b0;
    set_px(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    pv = 1'b0; pc = 1'b0; pe = '0; pn = ""; ph = 1'b0; pvb = 1'b0;

    tbl[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, "fg_priority"};
    tbl[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h1F, "grid_over_star"};
    tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, "grid_display_off"};
    tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h1F, "grid_line3"};
    tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h6D, "grid_hidden_l4_star_lo"};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, "grid_hidden_l5"};
    tbl[6] = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, "fg_opaque_black"};
    tbl[7] = '{1'b1, 8'h1C, 1'b1, 1'b0, 1'b0, 1'b1, 8'h1C, "fg_1c"};
    tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'hFF, "star_hi"};
    tbl[9] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, "empty_bg"};
    a_on  = 9'b0_0101_0101;
    b_sou = 13'b0_0000_0001_0001;
    b_on  = 13'b0_0101_0101_0101;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rgb", rgb, 8'h00);
    chk("rst_hblk", {7'd0, o_hb}, 8'h00);
    chk("rst_vblk", {7'd0, o_vb}, 8'h00);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rel_rgb", rgb, 8'h00);

    // frame 1: first FS gives reveal 4
    display = 1'b1;
    vblank(3);
    foreach (tbl[i]) begin
      set_px(tbl[i].fg_op, tbl[i].fg, tbl[i].starn, tbl[i].radarn, tbl[i].noise);
      display = tbl[i].display;
      line1(tbl[i].exp, tbl[i].name);
    end
    display = 1'b1;
    set_px(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    pix(1'b1, 1'b1, 1'b1, 8'hFF, "noise0_a");
    noise = 1'b1; pix(1'b1, 1'b1, 1'b1, 8'h6D, "noise1_a");
    noise = 1'b0; pix(1'b1, 1'b1, 1'b1, 8'hFF, "noise0_b");
    noise = 1'b1; pix(1'b1, 1'b1, 1'b1, 8'h6D, "noise1_b");
    pix(1'b0, 1'b1, 1'b1, 8'h00, "hblank_black");
    noise = 1'b0;

    // frames 2..70: grid on lines below 4*N, saturating at 256
    set_px(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    for (int n = 2; n <= 70; n++) begin
      int nl;
      nl = (4 * n <= 255) ? 4 * n + 1 : 256;
      vblank(3);
      for (int l = 0; l < nl; l++)
        line1((l < 4 * n) ? 8'h1F : 8'h00, $sformatf("reveal_f%0d_l%0d", n, l));
    end

    // DISPLAY low at FS clears reveal; next frame redraws from 4
    display = 1'b0;
    vblank(3);
    line1(8'h00, "disp0_l0");
    display = 1'b1;
    for (int l = 1; l < 4; l++) line1(8'h00, "disp0_hidden");
    vblank(3);
    for (int l = 0; l < 5; l++) line1((l < 4) ? 8'h1F : 8'h00, "redraw");

    // single hit flash, then a retrigger in the fifth flash frame
    for (int k = 0; k < 9; k++) flash_frame(1'(k == 0), a_on[k], $sformatf("flashA_k%0d", k));
    for (int k = 0; k < 13; k++) flash_frame(b_sou[k], b_on[k], $sformatf("flashB_k%0d", k));
    sou2 = 1'b0;

    // clock-enable freeze mid-line
    vblank(3);
    set_px(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    line1(8'h1F, "frz_l0");
    set_px(1'b1, 8'h12, 1'b1, 1'b1, 1'b0);
    pix(1'b1, 1'b1, 1'b1, 8'h12, "frz_p1");
    fg = 8'h34;
    pix(1'b1, 1'b1, 1'b1, 8'h34, "frz_p2");
    en = 1'b0;
    fg = 8'h56;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("frz_rgb", rgb, 8'h12);
      chk("frz_hblk", {7'd0, o_hb}, 8'h01);
    end
    en = 1'b1;
    pix(1'b1, 1'b1, 1'b1, 8'h56, "frz_p3");
    pix(1'b0, 1'b1, 1'b1, 8'h00, "frz_hb");
    fg_op = 1'b0;

    // reset in the middle of an ON frame
    sou2 = 1'b1;
    vblank(3);
    set_px(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    pix(1'b1, 1'b1, 1'b1, 8'hE0, "rf_grid_on");
    sou2 = 1'b0;
    pix(1'b0, 1'b1, 1'b1, 8'h00, "rf_hb");
    radarn = 1'b1;
    pix(1'b1, 1'b1, 1'b1, 8'h20, "rf_bg_on");
    pix(1'b1, 1'b1, 1'b1, 8'h20, "rf_bg_on2");
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_rgb", rgb, 8'h00);
    chk("rst_mid_hblk", {7'd0, o_hb}, 8'h00);
    chk("rst_mid_vblk", {7'd0, o_vb}, 8'h00);
    rst = 1'b0;
    pv  = 1'b0;
    set_px(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    pix(1'b1, 1'b1, 1'b1, 8'h00, "rst_black_a");
    pix(1'b1, 1'b1, 1'b1, 8'h00, "rst_black_b");
    pix(1'b0, 1'b1, 1'b1, 8'h00, "rst_black_hb");
    pix(1'b1, 1'b1, 1'b1, 8'h00, "rst_black_c");
    pix(1'b0, 1'b1, 1'b1, 8'h00, "rst_black_hb2");
    vblank(3);
    set_px(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    for (int l = 0; l < 5; l++) line1((l < 4) ? 8'h1F : 8'h00, "post_rst_idle");
    vblank(2);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
